// File: rtl/sid_waveform_mixer_if.sv
// SID type package and the mixer's bus interface: model, phase strobes, waveform bits in; DAC value and OSC3 out.
// Pure declarations; no logic, no latency.
// No flow control; the phase strobes are free-running.

package sid;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    // One-hot SID cycle phase strobes; index constants name each strobe bit.
    typedef logic [3:0] phase_t;
    localparam int PHI1      = 0;
    localparam int PHI2      = 1;
    localparam int PHI2_PHI1 = 2;
    localparam int PHI1_PHI2 = 3;

    typedef struct packed {
        logic [3:0]  selector;   // {noise, pulse, saw, tri}
        logic [7:0]  noise;
        logic        pulse;
        logic [11:0] saw_tri;
    } waveform_i_t;

endpackage

interface sid_waveform_mixer_if;
    sid::model_e      model;
    sid::phase_t      phase;
    sid::waveform_i_t in;
    logic [11:0]      wav;
    logic [7:0]       osc3;

    modport master (output model, output phase, output in, input wav, input osc3);
    modport slave  (input model, input phase, input in, output wav, output osc3);
endinterface

// File: rtl/sid_waveform_mixer.sv
// Per-voice waveform mixer: ANDs the selected components into the 12-bit DAC value and models the floating-DAC hold/fade.
// Latency: inputs sampled on the clk after PHI1_PHI2, result visible one clk later; stable between samples.
// No backpressure: phase is free-running and one sample is taken per SID cycle unconditionally.

module sid_waveform_mixer #(
    parameter logic [19:0] HOLD_6581 = 20'h04000,
    parameter logic [19:0] HOLD_8580 = 20'h3F000
) (
    input  logic                   clk,
    input  logic                   res,
    sid_waveform_mixer_if.slave    bus
);

    logic        smp;
    logic [19:0] fcnt;
    logic [11:0] wav;
    logic [7:0]  osc3;

    logic [11:0] tri_c;
    logic [11:0] saw_c;
    logic [11:0] pul_c;
    logic [11:0] noi_c;
    logic [11:0] mix;
    logic [19:0] hold;
    logic        sel_none;
    logic        fade;
    logic [11:0] wav_nxt;

    // Only the PHI1_PHI2 strobe is used; the other phase bits are deliberately ignored.
    logic unused_phase;
    assign unused_phase = ^{bus.phase[sid::PHI1], bus.phase[sid::PHI2], bus.phase[sid::PHI2_PHI1]};

    assign bus.wav  = wav;
    assign bus.osc3 = osc3;

    // Sample strobe lags PHI1_PHI2 by one clk so late saw_tri updates of either model are captured.
    always_ff @(posedge clk) begin
        if (res) begin
            smp <= 1'b0;
        end else begin
            smp <= bus.phase[sid::PHI1_PHI2];
        end
    end

    // Component mix, hold time selection and fade decision for the next sample.
    always_comb begin
        tri_c    = {bus.in.saw_tri[10:0], 1'b0};
        saw_c    = bus.in.saw_tri;
        pul_c    = {12{bus.in.pulse}};
        noi_c    = {bus.in.noise, 4'b0000};
        sel_none = (bus.in.selector == 4'b0000);
        hold     = (bus.model == sid::MOS6581) ? HOLD_6581 : HOLD_8580;

        mix = 12'hFFF;
        if (bus.in.selector[0]) mix = mix & tri_c;
        if (bus.in.selector[1]) mix = mix & saw_c;
        if (bus.in.selector[2]) mix = mix & pul_c;
        if (bus.in.selector[3]) mix = mix & noi_c;
        // Nothing selected: the DAC input floats and keeps its last value.
        if (sel_none) mix = wav;

        // Greater-or-equal so a switch to the shorter hold clears on the next sample.
        fade    = sel_none && (fcnt >= (hold - 20'd1));
        wav_nxt = fade ? 12'h000 : mix;
    end

    // Output registers and float counter advance once per SID cycle on the sample strobe.
    always_ff @(posedge clk) begin
        if (res) begin
            wav  <= 12'h000;
            osc3 <= 8'h00;
            fcnt <= 20'd0;
        end else if (smp) begin
            wav  <= wav_nxt;
            osc3 <= wav_nxt[11:4];
            if (!sel_none) begin
                fcnt <= 20'd0;
            end else if (fcnt < hold) begin
                fcnt <= fcnt + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Directed bench for sid_waveform_mixer: component mixing, sample timing, floating-DAC hold/fade and reset.
// Expected values are hand-computed constants.
// Phase strobes free-run with a 4-clk SID cycle.

module tb_sid_waveform_mixer;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [1:0] ph_cnt = 2'd0;
    int         n_checks = 0;
    int         n_errors = 0;

    sid_waveform_mixer_if bus ();

    sid_waveform_mixer dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Free-running one-hot phase; ph_cnt==3 is PHI1_PHI2, so the sample clk is the one where ph_cnt==0.
    always @(negedge clk) ph_cnt <= ph_cnt + 2'd1;
    assign bus.phase = 4'b0001 << ph_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next sample clk.
    task automatic step();
        @(posedge clk);
        while (ph_cnt != 2'd0) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] sel, input logic [11:0] st, input logic p, input logic [7:0] nz);
        bus.in.selector = sel;
        bus.in.saw_tri  = st;
        bus.in.pulse    = p;
        bus.in.noise    = nz;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        bus.model = sid::MOS6581;
        set_in(4'b0000, 12'h000, 1'b0, 8'h00);

        // 1. reset for 3 clks, then idle with nothing selected
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wav", 32'(bus.wav), 32'h000);
        check_eq("rst_osc3", 32'(bus.osc3), 32'h00);
        check_eq("rst_fcnt", 32'(dut.fcnt), 32'h0);
        while (ph_cnt != 2'd1) begin
            @(posedge clk);
            #1;
        end
        res = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.wav !== 12'h000 || bus.osc3 !== 8'h00) bad++;
        end
        check_eq("idle_nonzero_cycles", 32'(bad), 32'd0);
        check_eq("idle_wav", 32'(bus.wav), 32'h000);

        // 2. saw only, then input change between samples must not show
        set_in(4'b0010, 12'hABC, 1'b0, 8'h00);
        step();
        check_eq("saw_wav", 32'(bus.wav), 32'hABC);
        check_eq("saw_osc3", 32'(bus.osc3), 32'hAB);
        bus.in.saw_tri = 12'h123;
        @(posedge clk);
        #1;
        check_eq("saw_hold_clk1", 32'(bus.wav), 32'hABC);
        @(posedge clk);
        #1;
        check_eq("saw_hold_clk2", 32'(bus.osc3), 32'hAB);
        step();
        check_eq("saw_next_smp", 32'(bus.wav), 32'h123);

        // 3. saw + tri
        set_in(4'b0011, 12'hFF0, 1'b0, 8'h00);
        step();
        check_eq("sawtri_wav", 32'(bus.wav), 32'hFE0);
        check_eq("sawtri_osc3", 32'(bus.osc3), 32'hFE);

        // 4. noise + pulse, then pulse low
        set_in(4'b1100, 12'h000, 1'b1, 8'h5A);
        step();
        check_eq("noipul_wav", 32'(bus.wav), 32'h5A0);
        check_eq("noipul_osc3", 32'(bus.osc3), 32'h5A);
        bus.in.pulse = 1'b0;
        step();
        check_eq("noipul_lo_wav", 32'(bus.wav), 32'h000);

        // single components and the full four-way AND
        set_in(4'b0001, 12'h9A5, 1'b0, 8'h00);
        step();
        check_eq("tri_wav", 32'(bus.wav), 32'h34A);
        set_in(4'b0100, 12'h000, 1'b1, 8'h00);
        step();
        check_eq("pul_wav", 32'(bus.wav), 32'hFFF);
        set_in(4'b1000, 12'hFFF, 1'b1, 8'hC3);
        step();
        check_eq("noi_wav", 32'(bus.wav), 32'hC30);
        set_in(4'b1111, 12'hFFF, 1'b1, 8'hFF);
        step();
        check_eq("all4_wav", 32'(bus.wav), 32'hFF0);

        // 5. 6581 floating-DAC hold then fade
        bus.model = sid::MOS6581;
        set_in(4'b0001, 12'h400, 1'b0, 8'h00);
        step();
        check_eq("hold_pre_wav", 32'(bus.wav), 32'h800);
        bus.in.selector = 4'b0000;
        bad = 0;
        for (int i = 1; i <= 16383; i++) begin
            step();
            if (bus.wav !== 12'h800) bad++;
        end
        check_eq("hold_glitches", 32'(bad), 32'd0);
        check_eq("hold_last_wav", 32'(bus.wav), 32'h800);
        check_eq("hold_last_fcnt", 32'(dut.fcnt), 32'd16383);
        step();
        check_eq("fade_wav", 32'(bus.wav), 32'h000);
        check_eq("fade_osc3", 32'(bus.osc3), 32'h00);
        repeat (3) step();
        check_eq("fade_stay_wav", 32'(bus.wav), 32'h000);
        check_eq("fade_sat_fcnt", 32'(dut.fcnt), 32'd16384);
        bus.in.selector = 4'b0001;
        step();
        check_eq("resel_wav", 32'(bus.wav), 32'h800);
        check_eq("resel_fcnt", 32'(dut.fcnt), 32'd0);

        // 6. reset mid-hold
        bus.in.selector = 4'b0000;
        repeat (100) step();
        check_eq("midhold_fcnt", 32'(dut.fcnt), 32'd100);
        check_eq("midhold_wav", 32'(bus.wav), 32'h800);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        check_eq("midrst_wav", 32'(bus.wav), 32'h000);
        check_eq("midrst_osc3", 32'(bus.osc3), 32'h00);
        check_eq("midrst_fcnt", 32'(dut.fcnt), 32'd0);
        repeat (3) step();
        check_eq("postrst_wav", 32'(bus.wav), 32'h000);
        set_in(4'b0010, 12'h777, 1'b0, 8'h00);
        step();
        check_eq("postrst_saw", 32'(bus.wav), 32'h777);
        check_eq("postrst_osc3", 32'(bus.osc3), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
